// File: rtl/xoodyak_sequencer.sv
// xoodyak_sequencer: Cyclist command FIFO with phase-rule checking, issuing
// each legal op to xoodyak_build as a fixed OP_CLKS-clock slot.
module xoodyak_sequencer #(
  parameter int DEPTH   = 4,
  parameter int OP_CLKS = 4,
  parameter int DW      = 352
) (
  input  logic          eph1,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic [4:0]    core_opmode,
  output logic [DW-1:0] core_data,
  output logic          core_start,
  output logic          busy,
  output logic          slot_done,
  output logic [4:0]    slot_op,
  output logic          err,
  output logic [1:0]    mode
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(OP_CLKS);
  localparam logic [1:0] M_HASH = 2'd1, M_KEYED = 2'd2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    mode_q, mode_d;
  logic          nonce_ok_q, nonce_ok_d, err_q, err_d;
  logic [4:0]    op_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic          push, pop, last, hold, legal, hash;
  logic [3:0]    func;
  always_comb begin
    cmd_ready = (count_q < CW'(DEPTH)) & ~reset;
    push = cmd_valid & cmd_ready;
    last = (state_q == RUN) && (sc_q == SW'(OP_CLKS - 1));
    hold = (state_q == RUN) && !last;
    pop = (count_q != '0) && ((state_q == IDLE) || last);
    hash = op_mem[rd_q][4];
    func = op_mem[rd_q][3:0];
    legal = (func <= 4'd1)
         || (hash && (func == 4'd3 || func == 4'd6) && mode_q == M_HASH)
         || (!hash && func == 4'd2 && mode_q == M_KEYED && nonce_ok_q)
         || (!hash && func >= 4'd3 && func <= 4'd8 && mode_q == M_KEYED);
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    state_d = hold ? RUN : IDLE;
    sc_d = hold ? sc_q + 1'b1 : '0;
    op_d = hold ? op_q : '0;
    data_d = hold ? data_q : '0;
    mode_d = mode_q;
    nonce_ok_d = nonce_ok_q;
    err_d = pop & ~legal;
    if (pop && legal) begin
      state_d = RUN;
      sc_d = '0;
      op_d = op_mem[rd_q];
      data_d = (hash && func == 4'd1) ? '0 : data_mem[rd_q];
      mode_d = (func != 4'd1) ? mode_q : hash ? M_HASH : M_KEYED;
      // idle gaps keep a pending nonce allowed; any other real op consumes it
      nonce_ok_d = (func == 4'd1) ? (nonce_ok_q | ~hash) : (func == 4'd0) ? nonce_ok_q : 1'b0;
    end
  end
  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q <= IDLE;
      sc_q <= '0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      op_q <= '0;
      data_q <= '0;
      mode_q <= '0;
      nonce_ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q <= sc_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      op_q <= op_d;
      data_q <= data_d;
      mode_q <= mode_d;
      nonce_ok_q <= nonce_ok_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge eph1) begin
    if (push) begin
      op_mem[wr_q] <= cmd_op;
      data_mem[wr_q] <= cmd_data;
    end
  end
  assign core_opmode = op_q;
  assign core_data = data_q;
  assign busy = state_q == RUN;
  assign core_start = busy && sc_q == '0;
  assign slot_done = last;
  assign slot_op = last ? op_q : '0;
  assign err = err_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_xoodyak_sequencer.sv
// tb_xoodyak_sequencer: directed Cyclist scenarios plus randomized command
// streams checked against a transaction-level model of the phase rules.
module tb_xoodyak_sequencer;
  localparam int DEPTH = 4, OP_CLKS = 4, DW = 352;
  logic eph1 = 0, reset = 1, cmd_valid = 0;
  logic [4:0] cmd_op = '0;
  logic [DW-1:0] cmd_data = '0;
  logic cmd_ready, core_start, busy, slot_done, err;
  logic [4:0] core_opmode, slot_op;
  logic [DW-1:0] core_data;
  logic [1:0] mode;
  xoodyak_sequencer #(.DEPTH(DEPTH), .OP_CLKS(OP_CLKS), .DW(DW)) dut (
    .eph1(eph1), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .core_opmode(core_opmode), .core_data(core_data),
    .core_start(core_start), .busy(busy), .slot_done(slot_done), .slot_op(slot_op),
    .err(err), .mode(mode));
  initial forever #5 eph1 = ~eph1;
  int cyc = 0, cmp = 0, bad = 0, hold_bad = 0;
  bit mon_en = 0;
  int st_cyc[$], dn_cyc[$], er_cyc[$], push_cyc[$];
  logic [4:0] st_op[$], dn_op[$];
  logic [DW-1:0] st_data[$];
  logic [1:0] st_mode[$];
  logic [4:0] cur_op;
  logic [DW-1:0] cur_data;
  initial forever begin
    @(posedge eph1);
    cyc++;
  end
  // slot log, plus a tally of slots whose outputs wobble and idle leakage
  initial forever begin
    @(negedge eph1);
    if (mon_en) begin
      if (core_start) begin
        st_cyc.push_back(cyc); st_op.push_back(core_opmode); st_data.push_back(core_data);
        st_mode.push_back(mode); cur_op = core_opmode; cur_data = core_data;
      end else if (busy && (core_opmode !== cur_op || core_data !== cur_data)) hold_bad++;
      if (!busy && (core_opmode !== 5'd0 || core_data !== '0 || core_start || slot_done)) hold_bad++;
      if (!slot_done && slot_op !== 5'd0) hold_bad++;
      if (slot_done) begin dn_cyc.push_back(cyc); dn_op.push_back(slot_op); end
      if (err) er_cyc.push_back(cyc);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom());
    return r;
  endfunction
  task automatic clear_mon();
    st_cyc.delete(); dn_cyc.delete(); er_cyc.delete(); push_cyc.delete();
    st_op.delete(); dn_op.delete(); st_data.delete(); st_mode.delete();
  endtask
  task automatic do_reset(input int n);
    @(negedge eph1);
    reset = 1; cmd_valid = 0;
    repeat (n) @(negedge eph1);
    reset = 0;
    clear_mon();
  endtask
  task automatic send(input logic [4:0] op, input logic [DW-1:0] d);
    int i = 0;
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    #1;
    while (!cmd_ready && i < 300) begin @(negedge eph1); #1; i++; end
    if (!cmd_ready) begin cmp++; bad++; $display("FAIL send_timeout got=ready0 exp=ready1"); end
    else push_cyc.push_back(cyc);
    @(negedge eph1);
  endtask
  task automatic drain();
    int q = 0, i = 0;
    cmd_valid = 0;
    while (q < 8 && i < 500) begin @(negedge eph1); q = busy ? 0 : q + 1; i++; end
    cmp++;
    if (q < 8) begin bad++; $display("FAIL drain_timeout got=busy exp=idle"); end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge eph1);
    cmp++;
    if ({cmd_ready, core_opmode, core_start, busy, slot_done, slot_op, err, mode} !== 17'd0 || core_data !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {cmd_ready, core_opmode, core_start, busy, slot_done, slot_op, err, mode});
    end
    mon_en = 1;
  endtask
  task automatic test_aead();
    logic [4:0] ops [6] = '{5'h01, 5'h02, 5'h03, 5'h03, 5'h04, 5'h06};
    logic [DW-1:0] d [6];
    do_reset(2);
    for (int i = 0; i < 6; i++) begin d[i] = rnd(); send(ops[i], d[i]); end
    drain();
    cmp++;
    if (st_cyc.size() != 6 || dn_cyc.size() != 6) begin bad++; $display("FAIL aead_slots got=%0d/%0d exp=6", st_cyc.size(), dn_cyc.size()); end
    else begin
      cmp++;
      if (st_cyc[0] - push_cyc[0] != 2) begin bad++; $display("FAIL aead_latency got=%0d exp=2", st_cyc[0] - push_cyc[0]); end
      for (int i = 0; i < 6; i++) begin
        cmp++;
        if (st_cyc[i] != st_cyc[0] + OP_CLKS * i || dn_cyc[i] != st_cyc[i] + OP_CLKS - 1) begin
          bad++; $display("FAIL aead_timing[%0d] got=%0d,%0d exp=%0d,%0d", i, st_cyc[i], dn_cyc[i], st_cyc[0] + OP_CLKS * i, st_cyc[i] + OP_CLKS - 1);
        end
        cmp++;
        if (dn_op[i] !== ops[i] || st_op[i] !== ops[i] || st_data[i] !== d[i] || st_mode[i] !== 2'd2) begin
          bad++; $display("FAIL aead_slot[%0d] got=op%h mode%0d exp=op%h mode2", i, dn_op[i], st_mode[i], ops[i]);
        end
      end
    end
    cmp++;
    if (er_cyc.size() != 0 || mode !== 2'd2 || hold_bad != 0) begin
      bad++; $display("FAIL aead_misc got=err%0d mode%0d hold%0d exp=0,2,0", er_cyc.size(), mode, hold_bad);
    end
  endtask
  task automatic test_hash();
    logic [4:0] ops [4] = '{5'h11, 5'h13, 5'h13, 5'h16};
    logic [DW-1:0] d [4];
    do_reset(2);
    for (int i = 0; i < 4; i++) begin d[i] = rnd(); send(ops[i], d[i]); end
    drain();
    cmp++;
    if (st_cyc.size() != 4) begin bad++; $display("FAIL hash_slots got=%0d exp=4", st_cyc.size()); end
    else for (int i = 0; i < 4; i++) begin
      cmp++;
      if (st_op[i] !== ops[i] || st_data[i] !== (i == 0 ? '0 : d[i]) || st_mode[i] !== 2'd1) begin
        bad++; $display("FAIL hash_slot[%0d] got=op%h mode%0d exp=op%h mode1", i, st_op[i], st_mode[i], ops[i]);
      end
    end
    cmp++;
    if (er_cyc.size() != 0 || mode !== 2'd1) begin bad++; $display("FAIL hash_misc got=err%0d mode%0d exp=0,1", er_cyc.size(), mode); end
  endtask
  task automatic test_illegal();
    do_reset(2);
    send(5'h03, rnd());
    drain();
    cmp++;
    if (er_cyc.size() != 1 || st_cyc.size() != 0 || mode !== 2'd0) begin
      bad++; $display("FAIL illegal_absorb got=err%0d slots%0d mode%0d exp=1,0,0", er_cyc.size(), st_cyc.size(), mode);
    end else begin
      cmp++;
      if (er_cyc[0] != push_cyc[0] + 2) begin bad++; $display("FAIL illegal_err_time got=%0d exp=%0d", er_cyc[0], push_cyc[0] + 2); end
    end
    clear_mon();
    send(5'h01, rnd()); send(5'h03, rnd()); send(5'h02, rnd());
    drain();
    cmp++;
    if (st_cyc.size() != 2 || er_cyc.size() != 1) begin
      bad++; $display("FAIL illegal_nonce got=slots%0d err%0d exp=2,1", st_cyc.size(), er_cyc.size());
    end else begin
      cmp++;
      if (st_op[0] !== 5'h01 || st_op[1] !== 5'h03 || er_cyc[0] != st_cyc[1] + OP_CLKS) begin
        bad++; $display("FAIL illegal_nonce_seq got=%h,%h err@%0d exp=01,03 err@%0d", st_op[0], st_op[1], er_cyc[0], st_cyc[1] + OP_CLKS);
      end
    end
  endtask
  task automatic test_fill();
    int off [7] = '{0, 1, 2, 3, 4, 6, 10};
    logic [DW-1:0] d [7];
    do_reset(2);
    for (int i = 0; i < 7; i++) begin d[i] = rnd(); send(i == 0 ? 5'h01 : 5'h03, d[i]); end
    drain();
    cmp++;
    if (push_cyc.size() != 7 || st_cyc.size() != 7) begin
      bad++; $display("FAIL fill_counts got=push%0d slots%0d exp=7,7", push_cyc.size(), st_cyc.size());
    end else for (int i = 0; i < 7; i++) begin
      cmp++;
      if (push_cyc[i] - push_cyc[0] != off[i]) begin bad++; $display("FAIL fill_accept[%0d] got=%0d exp=%0d", i, push_cyc[i] - push_cyc[0], off[i]); end
      cmp++;
      if (st_op[i] !== (i == 0 ? 5'h01 : 5'h03) || st_data[i] !== d[i]) begin bad++; $display("FAIL fill_slot[%0d] got=op%h exp=data match", i, st_op[i]); end
    end
  endtask
  task automatic test_reset_mid();
    logic [DW-1:0] d = rnd();
    do_reset(2);
    send(5'h01, rnd()); send(5'h03, rnd()); send(5'h03, rnd());
    cmd_valid = 0;
    for (int i = 0; i < 20 && !(st_cyc.size() > 0 && cyc == st_cyc[0] + 1); i++) @(negedge eph1);
    cmp++;
    if (st_cyc.size() != 1 || cyc != st_cyc[0] + 1) begin bad++; $display("FAIL midreset_setup got=slots%0d exp=1 at sc1", st_cyc.size()); end
    reset = 1;
    @(negedge eph1);
    cmp++;
    if ({cmd_ready, core_opmode, core_start, busy, slot_done, slot_op, err, mode} !== 17'd0 || core_data !== '0 || dn_cyc.size() != 0) begin
      bad++; $display("FAIL midreset_outputs got=%b done%0d exp=0", {cmd_ready, core_opmode, core_start, busy, slot_done, slot_op, err, mode}, dn_cyc.size());
    end
    reset = 0;
    clear_mon();
    repeat (12) @(negedge eph1);
    cmp++;
    if (st_cyc.size() != 0 || er_cyc.size() != 0 || mode !== 2'd0) begin
      bad++; $display("FAIL midreset_quiet got=slots%0d err%0d mode%0d exp=0,0,0", st_cyc.size(), er_cyc.size(), mode);
    end
    send(5'h01, d);
    drain();
    cmp++;
    if (st_cyc.size() != 1 || st_op[0] !== 5'h01 || st_data[0] !== d || st_cyc[0] != push_cyc[0] + 2) begin
      bad++; $display("FAIL midreset_fresh got=slots%0d exp=1 slot of op01 at push+2", st_cyc.size());
    end
  endtask
  task automatic test_idle_gap();
    logic [4:0] ops [3] = '{5'h01, 5'h00, 5'h02};
    logic [DW-1:0] d [3];
    do_reset(2);
    for (int i = 0; i < 3; i++) begin d[i] = rnd(); send(ops[i], d[i]); end
    drain();
    cmp++;
    if (st_cyc.size() != 3 || er_cyc.size() != 0) begin
      bad++; $display("FAIL gap_slots got=slots%0d err%0d exp=3,0", st_cyc.size(), er_cyc.size());
    end else for (int i = 0; i < 3; i++) begin
      cmp++;
      if (st_op[i] !== ops[i] || st_data[i] !== d[i] || st_cyc[i] != st_cyc[0] + OP_CLKS * i) begin
        bad++; $display("FAIL gap_slot[%0d] got=op%h @%0d exp=op%h @%0d", i, st_op[i], st_cyc[i], ops[i], st_cyc[0] + OP_CLKS * i);
      end
    end
  endtask
  task automatic test_random();
    logic [4:0] pool [16] = '{5'h00, 5'h01, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                              5'h07, 5'h08, 5'h11, 5'h13, 5'h16, 5'h12, 5'h19, 5'h0f};
    logic [4:0] eo[$], op;
    logic [DW-1:0] ed[$], d;
    logic [3:0] f;
    logic [1:0] m;
    bit nk, ok, h;
    int ee;
    for (int r = 0; r < 4; r++) begin
      do_reset(2);
      eo.delete(); ed.delete(); ee = 0; m = 0; nk = 0;
      for (int k = 0; k < 20; k++) begin
        op = pool[$urandom_range(15)]; d = rnd(); h = op[4]; f = op[3:0];
        if (f == 0) ok = 1;
        else if (f == 1) begin ok = 1; m = h ? 2'd1 : 2'd2; nk = nk | !h; end
        else if (h) ok = (f == 3 || f == 6) && m == 2'd1;
        else if (f == 2) ok = m == 2'd2 && nk;
        else ok = f <= 8 && m == 2'd2;
        if (ok && f > 1) nk = 0;
        if (ok) begin eo.push_back(op); ed.push_back((h && f == 1) ? '0 : d); end
        else ee++;
        send(op, d);
        if ($urandom_range(3) == 0) begin cmd_valid = 0; repeat ($urandom_range(6)) @(negedge eph1); end
      end
      drain();
      cmp++;
      if (st_cyc.size() != eo.size() || dn_cyc.size() != eo.size() || er_cyc.size() != ee || mode !== m) begin
        bad++; $display("FAIL rand%0d_counts got=slots%0d err%0d mode%0d exp=%0d,%0d,%0d", r, st_cyc.size(), er_cyc.size(), mode, eo.size(), ee, m);
      end else for (int i = 0; i < eo.size(); i++) begin
        cmp++;
        if (st_op[i] !== eo[i] || st_data[i] !== ed[i] || dn_cyc[i] != st_cyc[i] + OP_CLKS - 1) begin
          bad++; $display("FAIL rand%0d_slot[%0d] got=op%h exp=op%h", r, i, st_op[i], eo[i]);
        end
      end
    end
    cmp++;
    if (hold_bad != 0) begin bad++; $display("FAIL slot_stability got=%0d exp=0", hold_bad); end
  endtask
  initial begin
    test_reset();
    test_aead();
    test_hash();
    test_illegal();
    test_fill();
    test_reset_mid();
    test_idle_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
